p1_sprite_reader: RTL and testbench



---
 rtl/p1_sprite_reader_pkg.sv | 34 +++
 rtl/p1_sprite_reader_anim.sv | 71 +++++++
 rtl/p1_sprite_reader.sv | 74 +++++++
 tb/tb_p1_sprite_reader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p1_sprite_reader_pkg.sv
// Shared definitions for the sprite reader: action codes, ROM address field widths
// and the animation state encoding.
package p1_sprite_reader_pkg;

  localparam int SPRITE_W = 16;
  localparam int ROW_W    = 4;
  localparam int ACT_W    = 3;
  localparam int FRAME_W  = 3;
  localparam int ADDR_W   = ROW_W + ACT_W + FRAME_W;
  localparam int TICK_W   = 8;

  typedef enum logic [ACT_W-1:0] {
    ACT_STAY     = 3'd0,
    ACT_FORWARD  = 3'd1,
    ACT_BACKWARD = 3'd2,
    ACT_PUNCH    = 3'd3,
    ACT_KICK     = 3'd4
  } action_e;

  typedef enum logic {
    IDLE_LOOP = 1'b0,
    ONESHOT   = 1'b1
  } anim_state_e;

  // Codes 5..7 have no artwork, so they behave exactly like STAY
  function automatic action_e normalize_action(input logic [ACT_W-1:0] a);
    return (a > 3'd4) ? ACT_STAY : action_e'(a);
  endfunction

  function automatic logic is_oneshot(input action_e a);
    return (a == ACT_PUNCH) || (a == ACT_KICK);
  endfunction

endpackage

// File: rtl/p1_sprite_reader_anim.sv
// Animation controller: picks the current action on frame boundaries and steps
// through its four frames, running punch/kick once before returning to STAY.
module sprite_anim_ctrl
  import p1_sprite_reader_pkg::*;
#(
  parameter int FRAME_DIV = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACT_W-1:0]   action,
  input  logic               frame_tick,
  output logic [ACT_W-1:0]   cur_action,
  output logic [FRAME_W-1:0] frame,
  output logic               anim_busy,
  output logic               anim_done
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_DIV - 1);

  anim_state_e       state;
  action_e           req;
  action_e           cur;
  logic [1:0]        frame_idx;
  logic [TICK_W-1:0] tick_cnt;
  logic              step;

  assign req        = normalize_action(action);
  assign step       = (tick_cnt == TICK_LAST);
  assign cur_action = cur;
  assign frame      = {1'b0, frame_idx};

  // Everything changes only on frame_tick so a frame is never torn mid-image;
  // while a one-shot runs, new requests are ignored until it finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_LOOP;
      cur       <= ACT_STAY;
      frame_idx <= '0;
      tick_cnt  <= '0;
      anim_busy <= 1'b0;
      anim_done <= 1'b0;
    end else begin
      anim_done <= 1'b0;
      if (frame_tick) begin
        if (state == IDLE_LOOP && req != cur) begin
          cur       <= req;
          frame_idx <= '0;
          tick_cnt  <= '0;
          if (is_oneshot(req)) begin
            state     <= ONESHOT;
            anim_busy <= 1'b1;
          end
        end else if (step) begin
          tick_cnt <= '0;
          if (state == ONESHOT && frame_idx == 2'd3) begin
            cur       <= ACT_STAY;
            frame_idx <= '0;
            anim_done <= 1'b1;
            anim_busy <= 1'b0;
            state     <= IDLE_LOOP;
          end else begin
            frame_idx <= frame_idx + 2'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/p1_sprite_reader.sv
// Sprite pixel reader: forms the sprite ROM address from the scan position and
// turns the returned row into a registered pixel_on two clocks after the scan input.
module p1_sprite_reader
  import p1_sprite_reader_pkg::*;
#(
  parameter int SCALE     = 2,
  parameter int FRAME_DIV = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                video_on,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic [ACT_W-1:0]    action,
  input  logic                facing_left,
  input  logic                frame_tick,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SPRITE_W-1:0] bitmap,
  output logic                pixel_on,
  output logic                anim_busy,
  output logic                anim_done
);

  localparam int              SHIFT    = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam logic [9:0]      BOX      = 10'(SPRITE_W * SCALE);
  localparam logic [ROW_W-1:0] LAST_COL = ROW_W'(SPRITE_W - 1);

  logic [9:0]         dx;
  logic [9:0]         dy;
  logic               in_box;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   col;
  logic [ACT_W-1:0]   cur_action;
  logic [FRAME_W-1:0] frame;
  logic               s1_valid;
  logic [ROW_W-1:0]   s1_col;

  sprite_anim_ctrl #(
    .FRAME_DIV (FRAME_DIV)
  ) u_anim (
    .clk        (clk),
    .rst        (rst),
    .action     (action),
    .frame_tick (frame_tick),
    .cur_action (cur_action),
    .frame      (frame),
    .anim_busy  (anim_busy),
    .anim_done  (anim_done)
  );

  // Unsigned wrap makes positions left of / above the sprite huge, so they fail the box test
  assign dx       = pixel_x - pos_x;
  assign dy       = pixel_y - pos_y;
  assign in_box   = (dx < BOX) && (dy < BOX);
  assign row      = ROW_W'(dy >> SHIFT);
  assign col      = ROW_W'(dx >> SHIFT);
  assign rom_addr = {row, cur_action, frame};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_col   <= '0;
      pixel_on <= 1'b0;
    end else begin
      s1_valid <= in_box & video_on;
      s1_col   <= facing_left ? (LAST_COL - col) : col;
      // Sprite art stores 0 for opaque pixels, leftmost column in bit 15
      pixel_on <= s1_valid & ~bitmap[LAST_COL - s1_col];
    end
  end

endmodule

// File: tb/tb_p1_sprite_reader.sv
// Self-checking bench: two sprite readers (SCALE=1/FRAME_DIV=2 and SCALE=2/FRAME_DIV=1)
// checked against a behavioural ROM, pixel and animation model.
module tb_p1_sprite_reader;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] posx;
    logic [9:0] posy;
    logic       vo;
    logic       fl;
  } pix_t;

  logic       clk;
  logic       rst;
  logic [9:0] pixel_x, pixel_y, pos_x, pos_y;
  logic       video_on, facing_left, frame_tick;
  logic [2:0] action;

  logic [9:0]  rom_addr  [2];
  logic [15:0] bitmap    [2];
  logic        pixel_on  [2];
  logic        anim_busy [2];
  logic        anim_done [2];

  logic [15:0] rom [1024];

  int errors;
  int checks;

  int scale_of [2] = '{1, 2};
  int div_of   [2] = '{2, 1};
  int m_act    [2];
  int m_ticks  [2];
  bit m_busy   [2];
  bit m_done   [2];

  p1_sprite_reader #(.SCALE(1), .FRAME_DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .pos_x(pos_x), .pos_y(pos_y), .action(action), .facing_left(facing_left),
    .frame_tick(frame_tick), .rom_addr(rom_addr[0]), .bitmap(bitmap[0]),
    .pixel_on(pixel_on[0]), .anim_busy(anim_busy[0]), .anim_done(anim_done[0])
  );

  p1_sprite_reader #(.SCALE(2), .FRAME_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .pos_x(pos_x), .pos_y(pos_y), .action(action), .facing_left(facing_left),
    .frame_tick(frame_tick), .rom_addr(rom_addr[1]), .bitmap(bitmap[1]),
    .pixel_on(pixel_on[1]), .anim_busy(anim_busy[1]), .anim_done(anim_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External sprite ROM with one cycle of latency
  always @(posedge clk) begin
    bitmap[0] <= rom[rom_addr[0]];
    bitmap[1] <= rom[rom_addr[1]];
  end

  // Animation model: ticks counted since the current action was loaded
  function automatic int model_frame(input int i);
    return (m_ticks[i] / div_of[i]) % 4;
  endfunction

  function automatic logic [5:0] model_addr_lo(input int i);
    return {3'(m_act[i]), 3'(model_frame(i))};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_ticks[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_tick(input int i, input int a);
    int na;
    na = (a > 4) ? 0 : a;
    if (!m_busy[i] && na != m_act[i]) begin
      m_act[i] = na; m_ticks[i] = 0; m_busy[i] = (na == 3 || na == 4);
    end else begin
      m_ticks[i]++;
      if (m_busy[i] && m_ticks[i] == 4 * div_of[i]) begin
        m_act[i] = 0; m_ticks[i] = 0; m_busy[i] = 0; m_done[i] = 1;
      end
    end
  endtask

  function automatic bit model_pixel(input int i, input pix_t s);
    int dx, dy, sz, row, col, ec, addr;
    logic [15:0] w;
    dx = (int'(s.px) - int'(s.posx) + 1024) % 1024;
    dy = (int'(s.py) - int'(s.posy) + 1024) % 1024;
    sz = 16 * scale_of[i];
    if (!s.vo || dx >= sz || dy >= sz) return 1'b0;
    row  = dy / scale_of[i];
    col  = dx / scale_of[i];
    ec   = s.fl ? 15 - col : col;
    addr = row * 64 + m_act[i] * 8 + model_frame(i);
    w    = rom[addr];
    return !w[15 - ec];
  endfunction

  // One clock of control stimulus; starts and ends on a falling edge
  task automatic step(input logic tick, input logic [2:0] act);
    frame_tick = tick;
    action     = act;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (tick) model_tick(i, int'(act));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; frame_tick = 1'b1; action = 3'd3;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0; action = 3'd0;
    model_reset();
  endtask

  task automatic test_reset();
    video_on = 1'b1;
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pixel_on[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_pixel_on dut%0d: got %0b want 0", i, pixel_on[i]); end
      checks++;
      if (anim_busy[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy dut%0d: got %0b want 0", i, anim_busy[i]); end
      checks++;
      if (anim_done[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done dut%0d: got %0b want 0", i, anim_done[i]); end
      checks++;
      if (rom_addr[i][5:0] !== 6'd0) begin errors++; $display("[TB] FAIL reset_addr dut%0d: got %0h want 0", i, rom_addr[i][5:0]); end
    end
  endtask

  task automatic test_sprite_rows();
    pix_t q[$];
    pix_t s;
    bit [1:0] exp_q[$];
    bit [1:0] e;
    rom[{4'd0, 3'd0, 3'd0}] = 16'b1111110000111111;
    rom[{4'd5, 3'd0, 3'd0}] = 16'b1111101111010111;
    for (int f = 0; f < 2; f++)
      for (int y = 50; y <= 55; y += 5)
        for (int x = 96; x <= 122; x++) begin
          s.px = 10'(x); s.py = 10'(y); s.posx = 10'd100; s.posy = 10'd50;
          s.vo = 1'b1; s.fl = f[0];
          q.push_back(s);
        end
    // Scan points just left of / above the sprite and a blanked point inside it
    s.posx = 10'd100; s.posy = 10'd50; s.fl = 1'b0; s.vo = 1'b1;
    s.px = 10'd99;  s.py = 10'd50; q.push_back(s);
    s.px = 10'd106; s.py = 10'd49; q.push_back(s);
    s.px = 10'd107; s.py = 10'd50; s.vo = 1'b0; q.push_back(s);
    for (int k = 0; k < q.size() + 2; k++) begin
      if (k >= 2) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (pixel_on[i] !== e[i]) begin
            errors++;
            $display("[TB] FAIL row_pixel dut%0d x=%0d y=%0d fl=%0b: got %0b want %0b",
                     i, q[k-2].px, q[k-2].py, q[k-2].fl, pixel_on[i], e[i]);
          end
        end
      end
      if (k < q.size()) begin
        pixel_x = q[k].px; pixel_y = q[k].py; pos_x = q[k].posx; pos_y = q[k].posy;
        video_on = q[k].vo; facing_left = q[k].fl;
        exp_q.push_back({model_pixel(1, q[k]), model_pixel(0, q[k])});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame_step();
    int seq_a [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int t = 0; t < 9; t++) begin
      step(1'b1, 3'd1);
      step(1'b0, 3'd1);
      checks++;
      if (rom_addr[0][5:0] !== {3'd1, 3'(seq_a[t])}) begin
        errors++;
        $display("[TB] FAIL frame_seq tick%0d: got %0h want %0h", t, rom_addr[0][5:0], {3'd1, 3'(seq_a[t])});
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rom_addr[i][5:0] !== model_addr_lo(i)) begin
          errors++;
          $display("[TB] FAIL frame_addr dut%0d tick%0d: got %0h want %0h", i, t, rom_addr[i][5:0], model_addr_lo(i));
        end
        checks++;
        if (anim_busy[i] !== 1'b0) begin errors++; $display("[TB] FAIL frame_busy dut%0d: got %0b want 0", i, anim_busy[i]); end
      end
    end
  endtask

  task automatic test_random_pixels();
    bit [1:0] exp_q[$];
    bit [1:0] e;
    pix_t s;
    pix_t hist[$];
    for (int k = 0; k < 200 + 2; k++) begin
      if (k >= 2) begin
        e = exp_q.pop_front();
        s = hist.pop_front();
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (pixel_on[i] !== e[i]) begin
            errors++;
            $display("[TB] FAIL rand_pixel dut%0d x=%0d y=%0d pos=%0d,%0d fl=%0b: got %0b want %0b",
                     i, s.px, s.py, s.posx, s.posy, s.fl, pixel_on[i], e[i]);
          end
        end
      end
      if (k < 200) begin
        s.posx = 10'($urandom_range(0, 1023));
        s.posy = 10'($urandom_range(0, 1023));
        s.px   = 10'(int'(s.posx) + int'($urandom_range(0, 44)) - 4);
        s.py   = 10'(int'(s.posy) + int'($urandom_range(0, 44)) - 4);
        s.vo   = ($urandom_range(0, 7) != 0);
        s.fl   = 1'($urandom_range(0, 1));
        pixel_x = s.px; pixel_y = s.py; pos_x = s.posx; pos_y = s.posy;
        video_on = s.vo; facing_left = s.fl;
        exp_q.push_back({model_pixel(1, s), model_pixel(0, s)});
        hist.push_back(s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_oneshot();
    int ticks;
    int first_done [2];
    pulse_reset();
    step(1'b1, 3'd3);
    ticks = 0;
    first_done = '{-1, -1};
    for (int n = 0; n < 24; n++) begin
      if (n % 2 == 0) ticks++;
      step((n % 2 == 0), 3'd4);
      for (int i = 0; i < 2; i++) begin
        if (anim_done[i] === 1'b1 && first_done[i] < 0) first_done[i] = ticks;
        checks++;
        if (anim_busy[i] !== m_busy[i]) begin errors++; $display("[TB] FAIL oneshot_busy dut%0d n=%0d: got %0b want %0b", i, n, anim_busy[i], m_busy[i]); end
        checks++;
        if (anim_done[i] !== m_done[i]) begin errors++; $display("[TB] FAIL oneshot_done dut%0d n=%0d: got %0b want %0b", i, n, anim_done[i], m_done[i]); end
        checks++;
        if (rom_addr[i][5:0] !== model_addr_lo(i)) begin errors++; $display("[TB] FAIL oneshot_addr dut%0d n=%0d: got %0h want %0h", i, n, rom_addr[i][5:0], model_addr_lo(i)); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (first_done[i] != 4 * div_of[i]) begin
        errors++;
        $display("[TB] FAIL oneshot_len dut%0d: got %0d ticks want %0d", i, first_done[i], 4 * div_of[i]);
      end
    end
  endtask

  task automatic test_reset_mid_punch();
    pulse_reset();
    step(1'b1, 3'd3);
    step(1'b1, 3'd3);
    step(1'b1, 3'd0);
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (anim_busy[i] !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy dut%0d c=%0d: got %0b want 0", i, c, anim_busy[i]); end
        checks++;
        if (anim_done[i] !== 1'b0) begin errors++; $display("[TB] FAIL abort_done dut%0d c=%0d: got %0b want 0", i, c, anim_done[i]); end
        checks++;
        if (rom_addr[i][5:0] !== 6'd0) begin errors++; $display("[TB] FAIL abort_addr dut%0d c=%0d: got %0h want 0", i, c, rom_addr[i][5:0]); end
      end
      step(1'b0, 3'd0);
    end
  endtask

  task automatic test_random_actions();
    logic tick;
    logic [2:0] act;
    for (int n = 0; n < 300; n++) begin
      tick = ($urandom_range(0, 2) == 0);
      act  = 3'($urandom_range(0, 7));
      step(tick, act);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (anim_busy[i] !== m_busy[i]) begin errors++; $display("[TB] FAIL rand_busy dut%0d n=%0d: got %0b want %0b", i, n, anim_busy[i], m_busy[i]); end
        checks++;
        if (anim_done[i] !== m_done[i]) begin errors++; $display("[TB] FAIL rand_done dut%0d n=%0d: got %0b want %0b", i, n, anim_done[i], m_done[i]); end
        checks++;
        if (rom_addr[i][5:0] !== model_addr_lo(i)) begin errors++; $display("[TB] FAIL rand_addr dut%0d n=%0d: got %0h want %0h", i, n, rom_addr[i][5:0], model_addr_lo(i)); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; frame_tick = 1'b0; action = 3'd0;
    pixel_x = '0; pixel_y = '0; pos_x = '0; pos_y = '0;
    video_on = 1'b0; facing_left = 1'b0;
    for (int a = 0; a < 1024; a++) rom[a] = 16'($urandom);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_sprite_rows();
    test_frame_step();
    test_random_pixels();
    test_oneshot();
    test_reset_mid_punch();
    test_random_actions();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
